// File: rtl/lb_output_checker.sv
// Output-side checker for a line-buffer memory core.
// Rebuilds the expected delayed stream from snooped writes and scores valid_out/data_out.
module lb_output_checker #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 13,
    parameter int LATENCY     = 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  config_en,
    input  logic [31:0]           config_addr,
    input  logic [31:0]           config_data,
    input  logic                  wen_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    input  logic                  valid_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            state,
    output logic                  mismatch,
    output logic                  seq_err,
    output logic                  err_flag,
    output logic [15:0]           err_count,
    output logic [31:0]           match_count,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic [DATA_WIDTH-1:0] first_act
);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        FILL   = 2'd1,
        CHECK  = 2'd2
    } state_t;

    localparam int SW = $clog2(LATENCY + 1);

    state_t                 st;
    logic [DEPTH_WIDTH-1:0] depth;
    logic [DEPTH_WIDTH:0]   occ;
    logic [DATA_WIDTH-1:0]  prev;
    logic                   first_wr;
    logic [LATENCY-1:0]     pv;
    logic [DATA_WIDTH-1:0]  pd [LATENCY];
    logic [SW-1:0]          supp;

    logic                   cfg_hit;
    logic                   cfg_on;
    logic                   do_flush;
    logic                   do_cfg;
    logic                   do_wr;
    logic                   at_full;
    logic                   fill_done;
    logic [DATA_WIDTH-1:0]  exp_d;
    logic                   seq_bad;
    logic                   cmp_en;
    logic                   bad;
    logic                   good;

    assign state = st;

    // Event decode: config, flush and write priority, plus head-of-pipe comparison
    always_comb begin
        cfg_hit   = clk_en && config_en && (config_addr == 32'd0);
        cfg_on    = config_data[2] && (config_data[1:0] == 2'd0);
        do_flush  = clk_en && flush && !(cfg_hit && config_data[2]);
        do_cfg    = cfg_hit && !do_flush;
        do_wr     = clk_en && wen_in && (st != UNCONF) && !flush && !do_cfg;
        at_full   = (occ == {1'b0, depth});
        fill_done = (occ + (DEPTH_WIDTH+1)'(1)) == {1'b0, depth};
        exp_d     = data_in - DATA_WIDTH'(depth);
        seq_bad   = do_wr && !first_wr && (data_in != prev + DATA_WIDTH'(1));
        cmp_en    = clk_en && (st != UNCONF) && (supp == '0);
        bad       = (valid_out != pv[LATENCY-1]) ||
                    (valid_out && pv[LATENCY-1] && (data_out != pd[LATENCY-1]));
        good      = valid_out && pv[LATENCY-1] && (data_out == pd[LATENCY-1]);
    end

    // Mode, occupancy and input-sequence tracking
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            st       <= UNCONF;
            depth    <= '0;
            occ      <= '0;
            prev     <= '0;
            first_wr <= 1'b1;
            supp     <= '0;
        end else if (clk_en) begin
            if (do_cfg) begin
                depth    <= config_data[DEPTH_WIDTH+2:3];
                st       <= cfg_on ? FILL : UNCONF;
                occ      <= '0;
                first_wr <= 1'b1;
                supp     <= SW'(LATENCY);
            end else if (do_flush) begin
                occ      <= '0;
                first_wr <= 1'b1;
                supp     <= SW'(LATENCY);
                if (st == CHECK) st <= FILL;
            end else begin
                if (supp != '0) supp <= supp - SW'(1);
                if (do_wr) begin
                    prev     <= data_in;
                    first_wr <= 1'b0;
                    if (!at_full) occ <= occ + (DEPTH_WIDTH+1)'(1);
                    if (st == FILL && (at_full || fill_done)) st <= CHECK;
                end
            end
        end
    end

    // Expectation pipe, LATENCY stages deep
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pv <= '0;
            for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
        end else if (clk_en) begin
            if (do_cfg || do_flush) begin
                pv <= '0;
            end else begin
                pv[0] <= do_wr && at_full;
                pd[0] <= exp_d;
                for (int i = 1; i < LATENCY; i++) begin
                    pv[i] <= pv[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    // Scoreboard: pulses, saturating counters and first-error capture
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            mismatch    <= 1'b0;
            seq_err     <= 1'b0;
            err_flag    <= 1'b0;
            err_count   <= '0;
            match_count <= '0;
            first_exp   <= '0;
            first_act   <= '0;
        end else begin
            mismatch <= cmp_en && bad;
            seq_err  <= seq_bad;
            if (cmp_en && bad) begin
                err_flag <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!err_flag) begin
                    first_exp <= pd[LATENCY-1];
                    first_act <= data_out;
                end
            end
            if (cmp_en && good && match_count != 32'hFFFF_FFFF)
                match_count <= match_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_lb_output_checker.sv
// Directed bench for lb_output_checker.
// A tiny core emulator drives valid_out/data_out; expected checker results are hand values.
module tb_lb_output_checker;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        config_en;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        wen_in;
    logic [15:0] data_in;
    logic        flush;
    logic        valid_out;
    logic [15:0] data_out;
    logic [1:0]  state;
    logic        mismatch;
    logic        seq_err;
    logic        err_flag;
    logic [15:0] err_count;
    logic [31:0] match_count;
    logic [15:0] first_exp;
    logic [15:0] first_act;

    int n_cmp = 0;
    int n_bad = 0;
    int mis_pulses = 0;
    int seq_pulses = 0;

    int          tb_d = 0;
    int          tb_occ = 0;
    logic        tb_on = 1'b0;
    logic        pend_v = 1'b0;
    logic [15:0] pend_d = '0;
    logic        corrupt = 1'b0;

    lb_output_checker dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .clk_en      (clk_en),
        .config_en   (config_en),
        .config_addr (config_addr),
        .config_data (config_data),
        .wen_in      (wen_in),
        .data_in     (data_in),
        .flush       (flush),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .state       (state),
        .mismatch    (mismatch),
        .seq_err     (seq_err),
        .err_flag    (err_flag),
        .err_count   (err_count),
        .match_count (match_count),
        .first_exp   (first_exp),
        .first_act   (first_act)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (mismatch) mis_pulses++;
        if (seq_err) seq_pulses++;
    endtask

    // One core cycle: present last cycle's core output, then model this write
    task automatic step(input logic w, input logic [15:0] d, input logic f);
        valid_out = pend_v;
        data_out  = (corrupt && pend_v && pend_d == 16'd5) ? 16'd7 : pend_d;
        clk_en    = 1'b1;
        config_en = 1'b0;
        wen_in    = w;
        data_in   = d;
        flush     = f;
        if (f) begin
            pend_v = 1'b1;
            pend_d = 16'hDEAD;
            tb_occ = 0;
        end else if (w && tb_on) begin
            if (tb_occ == tb_d) begin
                pend_v = 1'b1;
                pend_d = 16'(d - tb_d);
            end else begin
                tb_occ++;
                pend_v = 1'b0;
            end
        end else begin
            pend_v = 1'b0;
        end
        tick();
    endtask

    task automatic cfg(input logic [31:0] v);
        valid_out   = pend_v;
        data_out    = pend_d;
        clk_en      = 1'b1;
        config_en   = 1'b1;
        config_addr = 32'd0;
        config_data = v;
        wen_in      = 1'b0;
        flush       = 1'b0;
        tick();
        config_en = 1'b0;
        tb_on     = v[2] && (v[1:0] == 2'd0);
        tb_d      = int'(v[15:3]);
        tb_occ    = 0;
        pend_v    = 1'b0;
    endtask

    task automatic garbage(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en    = 1'b1;
            wen_in    = 1'b1;
            data_in   = 16'(i * 3);
            valid_out = 1'b1;
            data_out  = 16'h1234;
            tick();
        end
        valid_out = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (state !== 2'd0) begin
            n_bad++; $display("FAIL rst_state got %0d want 0", state);
        end
        n_cmp++;
        if ({mismatch, seq_err, err_flag} !== 3'b000) begin
            n_bad++; $display("FAIL rst_flags got %b want 000", {mismatch, seq_err, err_flag});
        end
        n_cmp++;
        if (err_count !== 16'd0 || match_count !== 32'd0) begin
            n_bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", err_count, match_count);
        end
    endtask

    task automatic test_fill_check();
        mis_pulses = 0; seq_pulses = 0;
        cfg(32'h0000_007C);
        n_cmp++;
        if (state !== 2'd1) begin
            n_bad++; $display("FAIL cfg_state got %0d want 1", state);
        end
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 14) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_bad++; $display("FAIL fill_state got %0d want 1", state);
                end
            end
            if (i == 15) begin
                n_cmp++;
                if (state !== 2'd2) begin
                    n_bad++; $display("FAIL check_state got %0d want 2", state);
                end
            end
            if (i == 17) begin
                n_cmp++;
                if (match_count !== 32'd1) begin
                    n_bad++; $display("FAIL first_match got %0d want 1", match_count);
                end
            end
        end
        step(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (match_count !== 32'd85) begin
            n_bad++; $display("FAIL match_85 got %0d want 85", match_count);
        end
        n_cmp++;
        if (err_count !== 16'd0 || err_flag !== 1'b0 || mis_pulses != 0 || seq_pulses != 0) begin
            n_bad++;
            $display("FAIL clean_run got err=%0d flag=%b mis=%0d seq=%0d want 0", err_count, err_flag, mis_pulses, seq_pulses);
        end
    endtask

    task automatic test_corrupt();
        mis_pulses = 0;
        cfg(32'h0000_007C);
        corrupt = 1'b1;
        for (int i = 1; i <= 30; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'd0, 1'b0);
        corrupt = 1'b0;
        n_cmp++;
        if (mis_pulses != 1 || err_count !== 16'd1) begin
            n_bad++; $display("FAIL corrupt_count got pulses=%0d err=%0d want 1/1", mis_pulses, err_count);
        end
        n_cmp++;
        if (first_exp !== 16'd5 || first_act !== 16'd7) begin
            n_bad++; $display("FAIL first_rec got %0d/%0d want 5/7", first_exp, first_act);
        end
        n_cmp++;
        if (err_flag !== 1'b1 || match_count !== 32'd99) begin
            n_bad++; $display("FAIL corrupt_tail got flag=%b match=%0d want 1/99", err_flag, match_count);
        end
    endtask

    task automatic test_flush();
        mis_pulses = 0; seq_pulses = 0;
        cfg(32'h0000_007C);
        for (int i = 1; i <= 40; i++) step(1'b1, 16'(i), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 16'(40 + k), 1'b1);
            if (k == 1) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_bad++; $display("FAIL flush_state got %0d want 1", state);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 16'(200 + i), 1'b0);
            if (i == 13) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_bad++; $display("FAIL refill_state got %0d want 1", state);
                end
            end
            if (i == 14) begin
                n_cmp++;
                if (state !== 2'd2) begin
                    n_bad++; $display("FAIL recheck_state got %0d want 2", state);
                end
            end
        end
        step(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (mis_pulses != 0 || seq_pulses != 0 || err_count !== 16'd1) begin
            n_bad++; $display("FAIL flush_clean got mis=%0d seq=%0d err=%0d want 0/0/1", mis_pulses, seq_pulses, err_count);
        end
        n_cmp++;
        if (match_count !== 32'd139 || err_flag !== 1'b1) begin
            n_bad++; $display("FAIL flush_match got %0d flag=%b want 139/1", match_count, err_flag);
        end
    endtask

    task automatic test_seq_jump();
        mis_pulses = 0; seq_pulses = 0;
        cfg(32'h0000_007C);
        for (int i = 1; i <= 20; i++) step(1'b1, 16'(i), 1'b0);
        for (int i = 25; i <= 34; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 25) begin
                n_cmp++;
                if (seq_err !== 1'b1) begin
                    n_bad++; $display("FAIL seq_pulse got %b want 1", seq_err);
                end
            end
        end
        step(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (seq_pulses != 1 || mis_pulses != 0) begin
            n_bad++; $display("FAIL seq_count got seq=%0d mis=%0d want 1/0", seq_pulses, mis_pulses);
        end
        n_cmp++;
        if (match_count !== 32'd154) begin
            n_bad++; $display("FAIL seq_match got %0d want 154", match_count);
        end
    endtask

    task automatic test_freeze();
        mis_pulses = 0;
        cfg(32'h0000_007C);
        for (int i = 1; i <= 20; i++) step(1'b1, 16'(i), 1'b0);
        n_cmp++;
        if (match_count !== 32'd158 || state !== 2'd2) begin
            n_bad++; $display("FAIL pre_freeze got %0d st=%0d want 158/2", match_count, state);
        end
        for (int i = 0; i < 10; i++) begin
            clk_en    = 1'b0;
            wen_in    = 1'b1;
            data_in   = 16'(500 + i);
            valid_out = i[0];
            data_out  = 16'(i);
            tick();
        end
        n_cmp++;
        if (match_count !== 32'd158 || state !== 2'd2 || mis_pulses != 0 || err_count !== 16'd1) begin
            n_bad++;
            $display("FAIL freeze_hold got match=%0d st=%0d mis=%0d err=%0d want 158/2/0/1", match_count, state, mis_pulses, err_count);
        end
        for (int i = 21; i <= 30; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (match_count !== 32'd169 || mis_pulses != 0) begin
            n_bad++; $display("FAIL resume got match=%0d mis=%0d want 169/0", match_count, mis_pulses);
        end
    endtask

    task automatic test_d0();
        mis_pulses = 0;
        cfg(32'h0000_0004);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 1) begin
                n_cmp++;
                if (state !== 2'd2) begin
                    n_bad++; $display("FAIL d0_state got %0d want 2", state);
                end
            end
        end
        step(1'b0, 16'd0, 1'b0);
        for (int i = 6; i <= 10; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (match_count !== 32'd179 || mis_pulses != 0) begin
            n_bad++; $display("FAIL d0_match got %0d mis=%0d want 179/0", match_count, mis_pulses);
        end
        cfg(32'h0000_0000);
        n_cmp++;
        if (state !== 2'd0) begin
            n_bad++; $display("FAIL disable_state got %0d want 0", state);
        end
        garbage(4);
        n_cmp++;
        if (mis_pulses != 0 || match_count !== 32'd179 || err_count !== 16'd1) begin
            n_bad++; $display("FAIL unconf_quiet got mis=%0d match=%0d err=%0d want 0/179/1", mis_pulses, match_count, err_count);
        end
    endtask

    task automatic test_reset_mid();
        mis_pulses = 0;
        cfg(32'h0000_007C);
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 2'd0 || err_flag !== 1'b0 || err_count !== 16'd0) begin
            n_bad++; $display("FAIL async_rst got st=%0d flag=%b err=%0d want 0/0/0", state, err_flag, err_count);
        end
        n_cmp++;
        if (match_count !== 32'd0 || first_exp !== 16'd0 || first_act !== 16'd0) begin
            n_bad++; $display("FAIL async_rst_rec got %0d %0d %0d want 0", match_count, first_exp, first_act);
        end
        #1;
        reset  = 1'b1;
        tb_on  = 1'b0;
        pend_v = 1'b0;
        garbage(3);
        n_cmp++;
        if (mis_pulses != 0 || err_count !== 16'd0 || state !== 2'd0) begin
            n_bad++; $display("FAIL post_rst got mis=%0d err=%0d st=%0d want 0/0/0", mis_pulses, err_count, state);
        end
    endtask

    initial begin
        reset       = 1'b0;
        clk_en      = 1'b0;
        config_en   = 1'b0;
        config_addr = '0;
        config_data = '0;
        wen_in      = 1'b0;
        data_in     = '0;
        flush       = 1'b0;
        valid_out   = 1'b0;
        data_out    = '0;
        repeat (2) @(posedge clk_in);
        #1;
        test_reset();
        reset = 1'b1;
        tick();
        test_fill_check();
        test_corrupt();
        test_flush();
        test_seq_jump();
        test_freeze();
        test_d0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lb_output_checker.md
# lb_output_checker

Synthesizable stream checker that sits on the output side of `memory_core_unq1` in line-buffer mode and verifies `valid_out`/`data_out` against the writes the core has received. It snoops the same config bus, `wen_in`/`data_in` and `flush` that drive the core, and computes the expected delayed stream (depth-`D` line buffer over a +1-incrementing input). It flags mismatches, counts them and keeps a sticky record of the first error, for use in CGRA tile benches and FPGA bring-up.

## Interface
- `DATA_WIDTH`, 16, width of `data_in` / `data_out`
- `DEPTH_WIDTH`, 13, width of the line-buffer depth field
- `LATENCY`, 1, core output latency in cycles (≥1) from `wen_in` sample to `valid_out`/`data_out`
- `clk_in`  in  1  clock, rising edge; the only clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `clk_en`  in  1  global clock enable; 0 freezes all state
- `config_en`  in  1  config write strobe
- `config_addr`  in  32  config address; only address 0 is decoded
- `config_data`  in  32  [1:0] mode, [2] enable, [15:3] depth `D`
- `wen_in`  in  1  write strobe into the core
- `data_in`  in  DATA_WIDTH  data written into the core
- `flush`  in  1  core flush
- `valid_out`  in  1  core output valid
- `data_out`  in  DATA_WIDTH  core output data
- `state`  out  2  0 UNCONF, 1 FILL, 2 CHECK
- `mismatch`  out  1  one-cycle registered error pulse
- `seq_err`  out  1  one-cycle pulse: stimulus not +1 incrementing
- `err_flag`  out  1  sticky OR of `mismatch`
- `err_count`  out  16  saturating mismatch count
- `match_count`  out  32  saturating count of correct valid beats
- `first_exp`, `first_act`  out  DATA_WIDTH  expected/actual data of first mismatch

## Operation
- Registers: `D`, `occ` (occupancy, DEPTH_WIDTH+1 bits), `prev` (last written data), `first_wr` flag, LATENCY-deep expectation pipe of {exp_valid, exp_data}.
- Config: `clk_en && config_en && config_addr==0`: latch `D`. If enable=1 and mode==0, go to FILL. Otherwise go to UNCONF. Either way clear `occ`, set `first_wr`, and clear the pipe. Counters and sticky fields are not cleared.
- UNCONF: no expectations generated. Pipe is fed exp_valid=0.
- Write (`clk_en && wen_in`, state ≠ UNCONF, `flush`=0):
  - If `!first_wr && data_in != prev+1` (mod 2^DATA_WIDTH), pulse `seq_err`.
  - Then `prev<=data_in` and `first_wr<=0`.
  - If `occ==D`, push exp_valid=1, exp_data=`data_in-D` (mod 2^DATA_WIDTH), and hold `occ`. Otherwise `occ<=occ+1` and push exp_valid=0.
  - `occ` reaching `D` moves FILL→CHECK.
- `D`=0: every write is in CHECK immediately; exp_data=`data_in`.
- No write: push exp_valid=0.
- `flush`=1 (with `clk_en`): clear `occ`, set `first_wr`, clear all pipe entries to exp_valid=0, CHECK→FILL. A simultaneous write is ignored. Flush beats config only when the config write is not enable; config has priority otherwise.
- Compare, every `clk_en` cycle, using the pipe head:
  - Mismatch if `valid_out != exp_valid`, or both are 1 and `data_out != exp_data`.
  - Both 1 with equal data: `match_count++` (saturating at all-ones).
  - Compare is suppressed in UNCONF and for LATENCY cycles after a flush or config write.
- On mismatch: `mismatch`=1 next cycle, `err_flag`<=1, `err_count++` (saturating at 0xFFFF). `first_exp`/`first_act` are loaded only while `err_flag`=0.

## Timing
- Reset (`reset`=0, async) clears everything: state=UNCONF, all outputs 0, `D`=0, `occ`=0, `first_wr`=1, pipe exp_valid=0.
- `clk_en`=0: no register changes. `mismatch`/`seq_err` hold 0 during freeze.
- Expectation for a write at edge t is compared against `valid_out`/`data_out` at edge t+LATENCY. `mismatch` is asserted in the cycle after that edge.
- `state` updates on the edge the triggering event is sampled.
- Reset asserted mid-stream takes effect immediately, without waiting for a clock. After reset, a config write is required before any checking.

## Test plan
- Reset, then config `0x0000_007C` (D=15, enable) and continuous writes 1,2,3…; the core models correctly. Result: state FILL for 15 writes, CHECK on write 16. `valid_out` is expected with data 1 when data_in=16. 100 writes give `match_count`=85 and `err_count`=0.
- Same setup with one injected `data_out` corruption, 0x0005→0x0007. Result: one `mismatch` pulse, `err_count`=1, `first_exp`=5, `first_act`=7, `err_flag` stays 1.
- Flush held 5 cycles after 40 writes. Result: state→FILL, comparisons suppressed for LATENCY cycles, the first post-flush valid is expected 15 writes later, and there is no `seq_err` on the first write after flush.
- Stimulus jumps 20→25 in CHECK. Result: `seq_err` pulses once, and expected data follows `data_in-15`.
- `clk_en`=0 for 10 cycles mid-CHECK with `valid_out` toggling. Result: no counter or state change, then checking resumes correctly.
- Config with D=0, then writes. Result: expected `data_out`=`data_in` with `valid_out`=`wen_in`. A config write with enable=0 returns state to UNCONF and stops all checks.
